// File: rtl/exe_stage.sv
// exe_stage
//   Execute stage of the 5-stage pipeline. Computes the ALU result, resolves
//   branches back to fetch (combinationally) and registers the results into
//   the EXE/MEM pipeline register for the memory stage.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   freeze              : memory-stage stall, holds the EXE/MEM register
//   val1, val2, reg2    : Rs operand, second ALU operand, Rt value (store/BNE)
//   pc_in               : PC+4 of this instruction
//   dest_in, wb_en_in   : writeback index / enable
//   mem_signal_in       : [1] load, [0] store
//   branch_type_in      : 00 none, 01 BEZ, 10 BNE, 11 JMP
//   exe_cmd_in          : ALU operation
//   br_taken, br_addr   : combinational branch redirect to fetch
//   alu_res, st_val, dest_out, wb_en_out, mem_r_en, mem_w_en, pc_out :
//                         EXE/MEM register outputs
//
// Flow control: there is no valid/ready handshake. freeze=1 holds every
// registered output for that edge and suppresses br_taken; rst overrides freeze.
module exe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] reg2,
  input  logic [WIDTH-1:0] val2,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [4:0]       dest_in,
  input  logic             wb_en_in,
  input  logic [1:0]       mem_signal_in,
  input  logic [1:0]       branch_type_in,
  input  logic [3:0]       exe_cmd_in,
  output logic             br_taken,
  output logic [WIDTH-1:0] br_addr,
  output logic [WIDTH-1:0] alu_res,
  output logic [WIDTH-1:0] st_val,
  output logic [4:0]       dest_out,
  output logic             wb_en_out,
  output logic             mem_r_en,
  output logic             mem_w_en,
  output logic [WIDTH-1:0] pc_out
);

  localparam logic [3:0] CMD_ADD = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0100;
  localparam logic [3:0] CMD_OR  = 4'b0101;
  localparam logic [3:0] CMD_NOR = 4'b0110;
  localparam logic [3:0] CMD_XOR = 4'b0111;
  localparam logic [3:0] CMD_SLL = 4'b1000;
  localparam logic [3:0] CMD_SRA = 4'b1001;
  localparam logic [3:0] CMD_SRL = 4'b1010;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEZ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_JMP  = 2'b11;

  logic [WIDTH-1:0] alu_comb;
  logic [4:0]       shamt;
  logic             br_cond;

  assign shamt = val2[4:0];

  // ALU
  always_comb begin
    alu_comb = '0;
    case (exe_cmd_in)
      CMD_ADD: alu_comb = val1 + val2;
      CMD_SUB: alu_comb = val1 - val2;
      CMD_AND: alu_comb = val1 & val2;
      CMD_OR:  alu_comb = val1 | val2;
      CMD_NOR: alu_comb = ~(val1 | val2);
      CMD_XOR: alu_comb = val1 ^ val2;
      CMD_SLL: alu_comb = val1 << shamt;
      CMD_SRA: alu_comb = $signed(val1) >>> shamt;
      CMD_SRL: alu_comb = val1 >> shamt;
      default: alu_comb = '0;
    endcase
  end

  // Branch resolution; the target is computed regardless of branch type.
  always_comb begin
    br_cond = 1'b0;
    case (branch_type_in)
      BR_NONE: br_cond = 1'b0;
      BR_BEZ:  br_cond = (val1 == '0);
      BR_BNE:  br_cond = (val1 != reg2);
      BR_JMP:  br_cond = 1'b1;
      default: br_cond = 1'b0;
    endcase
  end

  assign br_addr  = pc_in + (val2 << 2);
  // A frozen branch must not redirect fetch until the stall releases,
  // otherwise the redirect would be taken twice.
  assign br_taken = br_cond & ~freeze;

  // EXE/MEM pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_res   <= '0;
      st_val    <= '0;
      dest_out  <= '0;
      wb_en_out <= 1'b0;
      mem_r_en  <= 1'b0;
      mem_w_en  <= 1'b0;
      pc_out    <= '0;
    end else if (!freeze) begin
      alu_res   <= alu_comb;
      st_val    <= reg2;
      dest_out  <= dest_in;
      wb_en_out <= wb_en_in;
      mem_r_en  <= mem_signal_in[1];
      mem_w_en  <= mem_signal_in[0];
      pc_out    <= pc_in;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic [31:0] val1;
  logic [31:0] reg2;
  logic [31:0] val2;
  logic [31:0] pc_in;
  logic [4:0]  dest_in;
  logic        wb_en_in;
  logic [1:0]  mem_signal_in;
  logic [1:0]  branch_type_in;
  logic [3:0]  exe_cmd_in;
  logic        br_taken;
  logic [31:0] br_addr;
  logic [31:0] alu_res;
  logic [31:0] st_val;
  logic [4:0]  dest_out;
  logic        wb_en_out;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] pc_out;

  int tests_run;
  int tests_failed;

  logic [31:0] exp_q[$];

  exe_stage #(.WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .val1           (val1),
    .reg2           (reg2),
    .val2           (val2),
    .pc_in          (pc_in),
    .dest_in        (dest_in),
    .wb_en_in       (wb_en_in),
    .mem_signal_in  (mem_signal_in),
    .branch_type_in (branch_type_in),
    .exe_cmd_in     (exe_cmd_in),
    .br_taken       (br_taken),
    .br_addr        (br_addr),
    .alu_res        (alu_res),
    .st_val         (st_val),
    .dest_out       (dest_out),
    .wb_en_out      (wb_en_out),
    .mem_r_en       (mem_r_en),
    .mem_w_en       (mem_w_en),
    .pc_out         (pc_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] r2, input logic [31:0] pc, input logic [4:0] dest,
                       input logic wb, input logic [1:0] mem, input logic [1:0] br);
    exe_cmd_in     = cmd;
    val1           = v1;
    val2           = v2;
    reg2           = r2;
    pc_in          = pc;
    dest_in        = dest;
    wb_en_in       = wb;
    mem_signal_in  = mem;
    branch_type_in = br;
  endtask

  // ALU vector table: cmd, val1, val2, expected result
  logic [3:0]  alu_cmd [13];
  logic [31:0] alu_a   [13];
  logic [31:0] alu_b   [13];
  logic [31:0] alu_exp [13];

  initial begin
    alu_cmd[0]  = 4'b0010; alu_a[0]  = 32'd3;        alu_b[0]  = 32'd5;        alu_exp[0]  = 32'hFFFF_FFFE;
    alu_cmd[1]  = 4'b1001; alu_a[1]  = 32'h8000_0000; alu_b[1]  = 32'd4;       alu_exp[1]  = 32'hF800_0000;
    alu_cmd[2]  = 4'b1010; alu_a[2]  = 32'h8000_0000; alu_b[2]  = 32'd4;       alu_exp[2]  = 32'h0800_0000;
    alu_cmd[3]  = 4'b0110; alu_a[3]  = 32'd0;        alu_b[3]  = 32'd0;        alu_exp[3]  = 32'hFFFF_FFFF;
    alu_cmd[4]  = 4'b0100; alu_a[4]  = 32'h0000_F0F0; alu_b[4]  = 32'h0000_FF00; alu_exp[4]  = 32'h0000_F000;
    alu_cmd[5]  = 4'b0101; alu_a[5]  = 32'h0000_F0F0; alu_b[5]  = 32'h0000_FF00; alu_exp[5]  = 32'h0000_FFF0;
    alu_cmd[6]  = 4'b0111; alu_a[6]  = 32'h0000_F0F0; alu_b[6]  = 32'h0000_FF00; alu_exp[6]  = 32'h0000_0FF0;
    alu_cmd[7]  = 4'b1000; alu_a[7]  = 32'd1;        alu_b[7]  = 32'd31;       alu_exp[7]  = 32'h8000_0000;
    alu_cmd[8]  = 4'b1001; alu_a[8]  = 32'h8000_0000; alu_b[8]  = 32'd31;      alu_exp[8]  = 32'hFFFF_FFFF;
    alu_cmd[9]  = 4'b1010; alu_a[9]  = 32'h8000_0000; alu_b[9]  = 32'd31;      alu_exp[9]  = 32'h0000_0001;
    alu_cmd[10] = 4'b1010; alu_a[10] = 32'h1234_5678; alu_b[10] = 32'h0000_0020; alu_exp[10] = 32'h1234_5678;
    alu_cmd[11] = 4'b0011; alu_a[11] = 32'h1234_5678; alu_b[11] = 32'd1;       alu_exp[11] = 32'h0000_0000;
    alu_cmd[12] = 4'b0000; alu_a[12] = 32'hFFFF_FFFF; alu_b[12] = 32'd2;       alu_exp[12] = 32'h0000_0001;
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst    = 1'b1;
    freeze = 1'b0;
    drive(4'b0000, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 2'b00, 2'b00);
    tick();
    tick();
    rst = 1'b0;

    // reset state
    check("rst_alu_res", alu_res, 32'h0);
    check("rst_st_val", st_val, 32'h0);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_dest_out", 32'(dest_out), 32'h0);
    check("rst_wb_en", 32'(wb_en_out), 32'h0);
    check("rst_mem_r", 32'(mem_r_en), 32'h0);
    check("rst_mem_w", 32'(mem_w_en), 32'h0);
    check("rst_br_taken", 32'(br_taken), 32'h0);

    // ADD with writeback
    drive(4'b0000, 32'd5, 32'd7, 32'd0, 32'h10, 5'd3, 1'b1, 2'b00, 2'b00);
    #1;
    check("add_br_taken_pre", 32'(br_taken), 32'h0);
    check("add_alu_res_pre", alu_res, 32'h0);
    tick();
    check("add_alu_res", alu_res, 32'd12);
    check("add_dest", 32'(dest_out), 32'd3);
    check("add_wb_en", 32'(wb_en_out), 32'd1);
    check("add_pc_out", pc_out, 32'h10);
    check("add_br_taken", 32'(br_taken), 32'h0);

    // ALU table through the pipeline register
    for (int i = 0; i < 13; i++) begin
      drive(alu_cmd[i], alu_a[i], alu_b[i], 32'd0, 32'h20, 5'd1, 1'b1, 2'b00, 2'b00);
      exp_q.push_back(alu_exp[i]);
      tick();
      check($sformatf("alu_%0d", i), alu_res, exp_q.pop_front());
    end

    // branch resolution, same cycle
    drive(4'b0000, 32'd0, 32'd3, 32'd0, 32'h40, 5'd0, 1'b0, 2'b00, 2'b01);
    #1;
    check("bez_taken", 32'(br_taken), 32'd1);
    check("bez_addr", br_addr, 32'h4C);
    val1 = 32'd1;
    #1;
    check("bez_not_taken", 32'(br_taken), 32'd0);
    drive(4'b0000, 32'd9, 32'd3, 32'd9, 32'h40, 5'd0, 1'b0, 2'b00, 2'b10);
    #1;
    check("bne_equal", 32'(br_taken), 32'd0);
    reg2 = 32'd8;
    #1;
    check("bne_differ", 32'(br_taken), 32'd1);
    drive(4'b0000, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'h40, 5'd0, 1'b0, 2'b00, 2'b11);
    #1;
    check("jmp_taken", 32'(br_taken), 32'd1);
    check("jmp_addr", br_addr, 32'h3C);
    branch_type_in = 2'b00;
    #1;
    check("none_not_taken", 32'(br_taken), 32'd0);
    tick();

    // store
    drive(4'b0000, 32'h100, 32'd8, 32'hDEAD, 32'h44, 5'd0, 1'b0, 2'b01, 2'b00);
    tick();
    check("st_mem_w", 32'(mem_w_en), 32'd1);
    check("st_mem_r", 32'(mem_r_en), 32'd0);
    check("st_alu_res", alu_res, 32'h108);
    check("st_st_val", st_val, 32'hDEAD);
    check("st_wb_en", 32'(wb_en_out), 32'd0);
    check("st_pc_out", pc_out, 32'h44);

    // load, then freeze for 3 edges while inputs change
    drive(4'b0000, 32'h200, 32'd4, 32'h55, 32'h80, 5'd7, 1'b1, 2'b10, 2'b00);
    tick();
    check("ld_alu_res", alu_res, 32'h204);
    check("ld_mem_r", 32'(mem_r_en), 32'd1);
    check("ld_dest", 32'(dest_out), 32'd7);
    freeze = 1'b1;
    drive(4'b0000, 32'd1, 32'd1, 32'h66, 32'h90, 5'd9, 1'b0, 2'b00, 2'b11);
    #1;
    check("frz_jmp_suppressed", 32'(br_taken), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("frz_alu_res_%0d", k), alu_res, 32'h204);
      check($sformatf("frz_dest_%0d", k), 32'(dest_out), 32'd7);
      check($sformatf("frz_mem_r_%0d", k), 32'(mem_r_en), 32'd1);
      check($sformatf("frz_pc_%0d", k), pc_out, 32'h80);
      check($sformatf("frz_st_val_%0d", k), st_val, 32'h55);
    end
    freeze = 1'b0;
    #1;
    check("unfrz_jmp_taken", 32'(br_taken), 32'd1);
    tick();
    check("unfrz_alu_res", alu_res, 32'd2);
    check("unfrz_dest", 32'(dest_out), 32'd9);
    check("unfrz_pc", pc_out, 32'h90);
    check("unfrz_mem_r", 32'(mem_r_en), 32'd0);
    check("unfrz_wb_en", 32'(wb_en_out), 32'd0);
    check("unfrz_st_val", st_val, 32'h66);

    // nonzero outputs, then reset together with freeze
    drive(4'b0000, 32'h300, 32'd4, 32'hBEEF, 32'hA0, 5'd12, 1'b1, 2'b11, 2'b00);
    tick();
    check("pre_rst_alu_res", alu_res, 32'h304);
    rst    = 1'b1;
    freeze = 1'b1;
    tick();
    check("rstfrz_alu_res", alu_res, 32'h0);
    check("rstfrz_st_val", st_val, 32'h0);
    check("rstfrz_pc_out", pc_out, 32'h0);
    check("rstfrz_dest", 32'(dest_out), 32'h0);
    check("rstfrz_wb_en", 32'(wb_en_out), 32'h0);
    check("rstfrz_mem_r", 32'(mem_r_en), 32'h0);
    check("rstfrz_mem_w", 32'(mem_w_en), 32'h0);
    rst    = 1'b0;
    freeze = 1'b0;

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage pipelined core. It sits directly downstream of the decode stage and consumes the decode pipeline register outputs: operands, destination, PC and the decoded control fields. It computes the ALU result, resolves branches (taken flag and target address back to fetch), and registers the results into the EXE/MEM pipeline register for the memory stage.

## Interface
Parameters:
- `WIDTH`, default 32: datapath width. Only 32 is supported.

Ports:
- `clk`, input, 1: clock. All state updates on its rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `freeze`, input, 1: memory-stage stall. Holds the EXE/MEM register.
- `val1`, input, 32: Rs operand.
- `reg2`, input, 32: Rt register value, used as store data and as the BNE compare operand.
- `val2`, input, 32: second ALU operand, either Rt or the sign-extended immediate.
- `pc_in`, input, 32: byte address of the instruction following this one (PC+4).
- `dest_in`, input, 5: writeback register index.
- `wb_en_in`, input, 1: writeback enable.
- `mem_signal_in`, input, 2: bit1 = memory read (load), bit0 = memory write (store).
- `branch_type_in`, input, 2: 00 none, 01 BEZ, 10 BNE, 11 JMP.
- `exe_cmd_in`, input, 4: ALU operation.
- `br_taken`, output, 1: combinational; redirect fetch and flush fetch and decode.
- `br_addr`, output, 32: combinational; branch target.
- `alu_res`, output, 32: registered ALU result.
- `st_val`, output, 32: registered store data.
- `dest_out`, output, 5: registered destination index.
- `wb_en_out`, output, 1: registered.
- `mem_r_en`, output, 1: registered.
- `mem_w_en`, output, 1: registered.
- `pc_out`, output, 32: registered.

## Operation
ALU, combinational, all results mod 2^32:
- 0000 ADD: val1 + val2
- 0010 SUB: val1 − val2
- 0100 AND
- 0101 OR
- 0110 NOR
- 0111 XOR
- 1000 SLA/SLL: val1 << val2[4:0]
- 1001 SRA: arithmetic shift right by val2[4:0]
- 1010 SRL: logical shift right by val2[4:0]
- Any other code produces 0.

Loads and stores use ADD, so `alu_res` is the effective address val1 + imm.

Branch resolution:
- Condition by type:
  - BEZ: val1 == 0.
  - BNE: val1 != reg2.
  - JMP: always.
  - none: never.
- `br_addr` = pc_in + (val2 << 2), computed every cycle regardless of type.
- `br_taken` = condition AND NOT freeze. A frozen branch does not redirect until it is released.
- Branch instructions arrive with wb_en and mem_signal at 0. The stage does not modify the control fields it passes through.

EXE/MEM register, rising edge of clk:
- When rst: all registered outputs go to 0.
- Else when freeze: all registered outputs hold their values.
- Else: capture alu_res, st_val ← reg2, dest_in, wb_en_in, mem_signal_in[1] into mem_r_en, mem_signal_in[0] into mem_w_en, and pc_in.

## Timing
- ALU-to-register latency is 1 cycle: inputs present in cycle N appear on the registered outputs after edge N+1.
- `br_taken` and `br_addr` are valid in the same cycle the inputs are valid. The fetch stage samples them on the next edge.
- Reset values: `alu_res`, `st_val`, `pc_out` = 0x00000000; `dest_out` = 0; `wb_en_out`, `mem_r_en`, `mem_w_en` = 0. `br_taken` follows its inputs; after reset the decode register is zero, which gives type 00, so `br_taken` = 0.
- Reset mid-operation clears the register on that edge, even if freeze is asserted. rst has priority over freeze.
- Freeze held for K cycles holds the outputs for exactly K edges. The first unfrozen edge captures the current inputs.
- There is no internal forwarding. Hazards are resolved upstream.
- Shift amounts of 0 pass val1 unchanged. Shift amounts of 31 are legal.

## Test plan
1. ADD, val1=5, val2=7, wb_en=1, dest=3 → after one edge: alu_res=12, dest_out=3, wb_en_out=1; br_taken=0 throughout.
2. SUB, val1=3, val2=5 → alu_res=0xFFFFFFFE. SRA, val1=0x80000000, val2=4 → 0xF8000000. SRL with the same operands → 0x08000000. NOR, 0 and 0 → 0xFFFFFFFF.
3. BEZ, val1=0, pc_in=0x40, val2=3 → br_taken=1 and br_addr=0x4C in the same cycle. With val1=1 → br_taken=0. BNE, val1=reg2=9 → 0; reg2=8 → 1. JMP, val2=0xFFFFFFFF → br_addr=0x3C.
4. Store, mem_signal=01, val1=0x100, val2=8, reg2=0xDEAD → mem_w_en=1, alu_res=0x108, st_val=0xDEAD, wb_en_out=0.
5. Load captured, then freeze held 3 cycles while the inputs change → outputs unchanged for 3 edges. The first unfrozen edge captures the new inputs. JMP presented with freeze=1 → br_taken=0.
6. Outputs nonzero, assert rst together with freeze → all registered outputs are 0 after that edge.
